openram_bist_ctrl: RTL and testbench
====================================

OPENRAM_BIST_CTRL -- requirements
Module: openram_bist_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from read issue (csb0 low, web0 high) to dout0 valid; legal values 1..4.
REQ-002 SHALL have ports `clk` (in, 1): the single clock; every flop is rising-edge.
REQ-003 SHALL have port `reset_n` (in, 1): asynchronous, active-low reset.
REQ-004 SHALL have port `start` (in, 1): one-cycle request to begin a test.
REQ-005 SHALL have port `chip_sel` (in, 4): selects the SRAM under test; sampled on start.
REQ-006 SHALL have port `pattern` (in, 32): background data word; sampled on start.
REQ-007 SHALL have port `addr_max` (in, 16): last address tested; sampled on start.
REQ-008 SHALL have port `dout0` (in, 32): read data of the selected SRAM, muxed externally.
REQ-009 SHALL have ports `csb0` (out, 16), `web0` (out, 1), `wmask0` (out, 4), `addr0` (out, 16) and `din0` (out, 32): SRAM port-0 controls.
REQ-010 SHALL have status ports `busy` (out, 1), `done` (out, 1) and `fail` (out, 1).
REQ-011 SHALL have ports `err_count` (out, 16), `fail_addr` (out, 16) and `fail_data` (out, 32): mismatch count, plus address and data of the first mismatch.

Function
REQ-012 SHALL implement states IDLE, W0, R0W1, R1, DRAIN and DONE.
REQ-013 IDLE->W0 SHALL occur on start; start SHALL also latch the inputs and clear err_count, fail, fail_addr and fail_data.
REQ-014 W0 SHALL write pattern to addresses 0..addr_max in ascending order, one per cycle, with wmask0=4'hF.
REQ-015 R0W1 SHALL, per address ascending, spend two cycles: a read expecting pattern, then a write of ~pattern.
REQ-016 R1 SHALL read addresses addr_max..0 in descending order, one per cycle, expecting ~pattern; it SHALL leave after address 0 with no wrap to 16'hFFFF.
REQ-017 DRAIN SHALL last RD_LAT cycles so the final compare completes, then go to DONE.
REQ-018 DONE SHALL hold done=1 until the next start; start in DONE SHALL behave as in IDLE.
REQ-019 During an active access, csb0 SHALL be ~(16'h1 << chip_sel); otherwise csb0 SHALL be 16'hFFFF.
REQ-020 web0=0 SHALL mean write and web0=1 read; in non-access cycles web0 SHALL be 1.
REQ-021 The expected word and address of each read SHALL enter an RD_LAT-deep pipeline, and dout0 SHALL be compared at issue+RD_LAT.
REQ-022 On mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-023 On the first mismatch only, fail SHALL set and fail_addr/fail_data SHALL capture the address and dout0.
REQ-024 busy SHALL be 1 in W0, R0W1, R1 and DRAIN, and 0 otherwise.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 addr_max=0 SHALL test a single address.
REQ-027 Total busy cycles SHALL be 4*(addr_max+1)+RD_LAT.

Reset
REQ-028 reset_n low SHALL, at any time including mid-test, force IDLE immediately.
REQ-029 Reset SHALL set csb0=16'hFFFF, web0=1, wmask0=0, addr0=0, din0=0, busy=0, done=0, fail=0, err_count=0, fail_addr=0 and fail_data=0.
REQ-030 Reset SHALL flush the compare pipeline so that no compare occurs after reset release.

Configuration
REQ-031 With macro BIST_STOP_ON_FAIL_EN defined, the first mismatch SHALL abort the test to DONE on the next cycle, and err_count SHALL be 1.
REQ-032 Without BIST_STOP_ON_FAIL_EN, the test SHALL always run to completion, counting all mismatches.

Verification
REQ-033 Scenario: ideal SRAM model, addr_max=3, RD_LAT=1, pattern=32'hA5A5_5A5A, chip_sel=2 -> busy for 17 cycles, csb0=16'hFFFB during accesses, done=1, fail=0, err_count=0.
REQ-034 Scenario: model with bit 0 stuck at 1 at address 5, addr_max=7, pattern=0 -> fail=1, fail_addr=5, fail_data=32'h1, err_count=1 (R0W1 read; R1 expects ~0, so no error there).
REQ-035 Scenario: addr_max=0, RD_LAT=3 -> exactly 3 accesses (W, R, W), then 1 R, busy for 7 cycles, addr0 never outside 0.
REQ-036 Scenario: reset_n pulsed low during R0W1 -> csb0=16'hFFFF and busy=0 at once; a later start runs a clean pass with err_count=0.
REQ-037 Scenario: start pulsed while busy -> no restart, cycle count unchanged.
REQ-038 Scenario: BIST_STOP_ON_FAIL_EN with every word faulty at addr_max=15 -> done asserted 1 cycle after the first compare (cycle 18 after start), err_count=1.

Source files
------------

// File: rtl/openram_bist_ctrl.sv
// March-style BIST sequencer for one OpenRAM port-0: W0, R0W1 ascending, then R1 descending.
// Define BIST_STOP_ON_FAIL_EN to abort to DONE on the first mismatch instead of counting all.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start, SRAM port deselected
// W0      | write background pattern, addresses 0..addr_max
// R0W1    | per address ascending: read expecting pattern, write ~pattern
// R1      | read expecting ~pattern, addresses addr_max..0
// DRAIN   | RD_LAT cycles so the last read's compare lands
// DONE    | test finished, results held until the next start
module openram_bist_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  chip_sel,
    input  logic [31:0] pattern,
    input  logic [15:0] addr_max,
    input  logic [31:0] dout0,
    output logic [15:0] csb0,
    output logic        web0,
    output logic [3:0]  wmask0,
    output logic [15:0] addr0,
    output logic [31:0] din0,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [15:0] err_count,
    output logic [15:0] fail_addr,
    output logic [31:0] fail_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_W0    = 3'd1;
    localparam logic [2:0] S_R0W1  = 3'd2;
    localparam logic [2:0] S_R1    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state, state_d;
    logic [15:0] addr_q, addr_d;
    logic        phase_q, phase_d;
    logic [2:0]  drain_cnt, drain_d;
    logic [3:0]  chip_sel_q;
    logic [31:0] pattern_q;
    logic [15:0] addr_max_q;

    logic        pipe_vld  [RD_LAT];
    logic [31:0] pipe_exp  [RD_LAT];
    logic [15:0] pipe_addr [RD_LAT];

    logic        access, is_write, is_read, start_ok, mismatch, abort;
    logic [31:0] exp_word;

    always_comb begin
        access   = (state == S_W0) || (state == S_R0W1) || (state == S_R1);
        is_write = (state == S_W0) || ((state == S_R0W1) && phase_q);
        is_read  = access && !is_write;
        start_ok = start && ((state == S_IDLE) || (state == S_DONE));
        exp_word = (state == S_R1) ? ~pattern_q : pattern_q;

        csb0   = access ? ~(16'h1 << chip_sel_q) : 16'hFFFF;
        web0   = ~is_write;
        wmask0 = is_write ? 4'hF : 4'h0;
        addr0  = access ? addr_q : 16'h0;
        if (state == S_W0)
            din0 = pattern_q;
        else if (is_write)
            din0 = ~pattern_q;
        else
            din0 = 32'h0;

        busy = (state == S_W0) || (state == S_R0W1) || (state == S_R1) || (state == S_DRAIN);
        done = (state == S_DONE);
    end

    assign mismatch = pipe_vld[RD_LAT-1] && (dout0 != pipe_exp[RD_LAT-1]);

`ifdef BIST_STOP_ON_FAIL_EN
    assign abort = mismatch;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_cnt;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_W0;
                    addr_d  = 16'h0;
                    phase_d = 1'b0;
                end
            end
            S_W0: begin
                if (addr_q == addr_max_q) begin
                    state_d = S_R0W1;
                    addr_d  = 16'h0;
                    phase_d = 1'b0;
                end else begin
                    addr_d = addr_q + 16'h1;
                end
            end
            S_R0W1: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == addr_max_q) begin
                        state_d = S_R1;
                        addr_d  = addr_max_q;
                    end else begin
                        addr_d = addr_q + 16'h1;
                    end
                end
            end
            S_R1: begin
                // Exit on address 0 rather than decrementing, so no wrap to 16'hFFFF.
                if (addr_q == 16'h0) begin
                    state_d = S_DRAIN;
                    drain_d = 3'(RD_LAT - 1);
                end else begin
                    addr_d = addr_q - 16'h1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 3'd0)
                    state_d = S_DONE;
                else
                    drain_d = drain_cnt - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_DONE;
            addr_d  = 16'h0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            addr_q     <= 16'h0;
            phase_q    <= 1'b0;
            drain_cnt  <= 3'd0;
            chip_sel_q <= 4'h0;
            pattern_q  <= 32'h0;
            addr_max_q <= 16'h0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            drain_cnt <= drain_d;
            if (start_ok) begin
                chip_sel_q <= chip_sel;
                pattern_q  <= pattern;
                addr_max_q <= addr_max;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_exp[i]  <= 32'h0;
                pipe_addr[i] <= 16'h0;
            end
        end else if (abort || start_ok) begin
            for (int i = 0; i < RD_LAT; i++)
                pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0]  <= is_read;
            pipe_exp[0]  <= exp_word;
            pipe_addr[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 16'h0;
            fail      <= 1'b0;
            fail_addr <= 16'h0;
            fail_data <= 32'h0;
        end else if (start_ok) begin
            err_count <= 16'h0;
            fail      <= 1'b0;
            fail_addr <= 16'h0;
            fail_data <= 32'h0;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF)
                err_count <= err_count + 16'h1;
            if (!fail) begin
                fail      <= 1'b1;
                fail_addr <= pipe_addr[RD_LAT-1];
                fail_data <= dout0;
            end
        end
    end

endmodule

// File: tb/tb_openram_bist_ctrl.sv
// Directed bench: two controllers (RD_LAT=1 and RD_LAT=3) each driving a small behavioural SRAM.
module tb_openram_bist_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start1, start3;
    logic [3:0]  chip_sel;
    logic [31:0] pattern;
    logic [15:0] addr_max;

    logic [31:0] dout1, dout3;
    logic [15:0] csb1, csb3, addr1, addr3, err1, err3, faddr1, faddr3;
    logic        web1, web3, busy1, busy3, done1, done3, fail1, fail3;
    logic [3:0]  wmask1, wmask3;
    logic [31:0] din1, din3, fdata1, fdata3;

    always #5 clk = ~clk;

    openram_bist_ctrl #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .chip_sel(chip_sel),
        .pattern(pattern), .addr_max(addr_max), .dout0(dout1),
        .csb0(csb1), .web0(web1), .wmask0(wmask1), .addr0(addr1), .din0(din1),
        .busy(busy1), .done(done1), .fail(fail1),
        .err_count(err1), .fail_addr(faddr1), .fail_data(fdata1)
    );

    openram_bist_ctrl #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .chip_sel(chip_sel),
        .pattern(pattern), .addr_max(addr_max), .dout0(dout3),
        .csb0(csb3), .web0(web3), .wmask0(wmask3), .addr0(addr3), .din0(din3),
        .busy(busy3), .done(done3), .fail(fail3),
        .err_count(err3), .fail_addr(faddr3), .fail_data(fdata3)
    );

    // SRAM models: 0 = ideal, 1 = bit 0 stuck at 1 at address 5, 2 = bit 31 flipped on every read
    int          fault_mode;
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] r3_0, r3_1, r3_2;

    function automatic logic [31:0] faulty(input logic [15:0] a, input logic [31:0] d);
        case (fault_mode)
            1:       return (a == 16'd5) ? (d | 32'h1) : d;
            2:       return d ^ 32'h8000_0000;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (csb1 != 16'hFFFF) begin
            if (!web1) mem1[addr1[7:0]] <= din1;
            else       dout1 <= faulty(addr1, mem1[addr1[7:0]]);
        end
        if (csb3 != 16'hFFFF) begin
            if (!web3) mem3[addr3[7:0]] <= din3;
            else       r3_0 <= mem3[addr3[7:0]];
        end
        r3_1 <= r3_0;
        r3_2 <= r3_1;
    end
    assign dout3 = r3_2;

    logic        use3;
    logic [15:0] s_csb, s_addr, s_err, s_faddr;
    logic        s_web, s_busy, s_done, s_fail;
    logic [3:0]  s_wmask;
    logic [31:0] s_din, s_fdata;
    assign s_csb   = use3 ? csb3   : csb1;
    assign s_addr  = use3 ? addr3  : addr1;
    assign s_web   = use3 ? web3   : web1;
    assign s_wmask = use3 ? wmask3 : wmask1;
    assign s_din   = use3 ? din3   : din1;
    assign s_busy  = use3 ? busy3  : busy1;
    assign s_done  = use3 ? done3  : done1;
    assign s_fail  = use3 ? fail3  : fail1;
    assign s_err   = use3 ? err3   : err1;
    assign s_faddr = use3 ? faddr3 : faddr1;
    assign s_fdata = use3 ? fdata3 : fdata1;

    int          n_check, n_err;
    int          bad_ctl, max_addr, busy_n;
    logic [15:0] last_csb;
    logic [48:0] got_q [$];
    logic [48:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_check++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_exp(input int amax, input logic [31:0] pat);
        exp_q.delete();
        for (int a = 0; a <= amax; a++) exp_q.push_back({1'b0, 16'(a), pat});
        for (int a = 0; a <= amax; a++) begin
            exp_q.push_back({1'b1, 16'(a), 32'h0});
            exp_q.push_back({1'b0, 16'(a), ~pat});
        end
        for (int a = amax; a >= 0; a--) exp_q.push_back({1'b1, 16'(a), 32'h0});
    endtask

    task automatic chk_seq(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        chk({tag, "_seq"}, 64'(bad), 64'd0);
    endtask

    // Pulses start on the chosen DUT and logs every access until done; extra_at re-pulses start mid-run.
    task automatic run_test(input logic sel3, input int extra_at, input logic [31:0] alt_pat);
        int n;
        use3 = sel3;
        got_q.delete();
        busy_n = 0; bad_ctl = 0; max_addr = 0; last_csb = 16'hFFFF;
        @(negedge clk);
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        n = 0;
        while (n < 3000) begin
            n++;
            if (s_done) break;
            if (s_busy) busy_n++;
            if (s_csb != 16'hFFFF) begin
                got_q.push_back({s_web, s_addr, s_web ? 32'h0 : s_din});
                last_csb = s_csb;
                if (int'(s_addr) > max_addr) max_addr = int'(s_addr);
                if (s_wmask != (s_web ? 4'h0 : 4'hF)) bad_ctl++;
            end else if (!s_web || s_wmask != 4'h0) begin
                bad_ctl++;
            end
            if (n == extra_at) begin
                if (sel3) start3 = 1'b1; else start1 = 1'b1;
                pattern = alt_pat;
            end
            @(negedge clk);
            start1 = 1'b0; start3 = 1'b0;
        end
        chk("run_done", 64'(s_done), 64'd1);
    endtask

    initial begin
        n_check = 0; n_err = 0;
        fault_mode = 0; use3 = 1'b0;
        reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        chip_sel = 4'd2; pattern = 32'hA5A5_5A5A; addr_max = 16'd3;
        r3_0 = 32'h0; dout1 = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_csb", 64'(csb1), 64'hFFFF);
        chk("rst_web", 64'(web1), 64'd1);
        chk("rst_wmask", 64'(wmask1), 64'd0);
        chk("rst_addr", 64'(addr1), 64'd0);
        chk("rst_din", 64'(din1), 64'd0);
        chk("rst_stat", 64'({busy1, done1, fail1}), 64'd0);
        chk("rst_err", 64'({err1, faddr1, fdata1}), 64'd0);
        reset_n = 1'b1;

        // ideal SRAM, addr_max=3, chip 2
        build_exp(3, 32'hA5A5_5A5A);
        run_test(1'b0, 0, 32'hA5A5_5A5A);
        chk("t1_busy", 64'(busy_n), 64'd17);
        chk("t1_csb", 64'(last_csb), 64'hFFFB);
        chk("t1_ctl", 64'(bad_ctl), 64'd0);
        chk_seq("t1");
        chk("t1_fail", 64'(fail1), 64'd0);
        chk("t1_err", 64'(err1), 64'd0);

        // bit 0 stuck at 1 at address 5
        fault_mode = 1; addr_max = 16'd7; pattern = 32'h0; chip_sel = 4'd0;
        run_test(1'b0, 0, 32'h0);
        chk("t2_busy", 64'(busy_n), 64'd33);
        chk("t2_csb", 64'(last_csb), 64'hFFFE);
        chk("t2_fail", 64'(fail1), 64'd1);
        chk("t2_faddr", 64'(faddr1), 64'd5);
        chk("t2_fdata", 64'(fdata1), 64'h1);
        chk("t2_err", 64'(err1), 64'd1);

        // start and a new pattern presented mid-run must be ignored
        fault_mode = 0; addr_max = 16'd3; pattern = 32'h1234_5678; chip_sel = 4'd15;
        build_exp(3, 32'h1234_5678);
        run_test(1'b0, 5, 32'hFFFF_0000);
        chk("t3_busy", 64'(busy_n), 64'd17);
        chk("t3_csb", 64'(last_csb), 64'h7FFF);
        chk_seq("t3");
        chk("t3_err", 64'(err1), 64'd0);
        chk("t3_fail", 64'(fail1), 64'd0);

        // every read faulty
        fault_mode = 2; pattern = 32'hA5A5_5A5A; chip_sel = 4'd3;
`ifdef BIST_STOP_ON_FAIL_EN
        addr_max = 16'd15;
        run_test(1'b0, 0, 32'hA5A5_5A5A);
        chk("t4_busy", 64'(busy_n), 64'd18);
        chk("t4_err", 64'(err1), 64'd1);
`else
        addr_max = 16'd3;
        run_test(1'b0, 0, 32'hA5A5_5A5A);
        chk("t4_busy", 64'(busy_n), 64'd17);
        chk("t4_err", 64'(err1), 64'd8);
`endif
        chk("t4_fail", 64'(fail1), 64'd1);
        chk("t4_faddr", 64'(faddr1), 64'd0);
        chk("t4_fdata", 64'(fdata1), 64'h25A5_5A5A);

        // RD_LAT=3, single address
        fault_mode = 0; addr_max = 16'd0; pattern = 32'hDEAD_BEEF; chip_sel = 4'd1;
        build_exp(0, 32'hDEAD_BEEF);
        run_test(1'b1, 0, 32'hDEAD_BEEF);
        chk("t5_busy", 64'(busy_n), 64'd7);
        chk("t5_csb", 64'(last_csb), 64'hFFFD);
        chk("t5_maxaddr", 64'(max_addr), 64'd0);
        chk("t5_ctl", 64'(bad_ctl), 64'd0);
        chk_seq("t5");
        chk("t5_err", 64'({fail3, err3}), 64'd0);

        // reset mid-R0W1 with a read of a faulty word still in flight
        fault_mode = 2; addr_max = 16'd3; pattern = 32'h0F0F_0F0F; chip_sel = 4'd2; use3 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_pre_busy", 64'(busy1), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_csb", 64'(csb1), 64'hFFFF);
        chk("t6_busy", 64'(busy1), 64'd0);
        chk("t6_web", 64'(web1), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_flush", 64'({fail1, err1}), 64'd0);
        fault_mode = 0;
        run_test(1'b0, 0, 32'h0F0F_0F0F);
        chk("t6_rerun_busy", 64'(busy_n), 64'd17);
        chk("t6_rerun_err", 64'({fail1, err1}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_check, n_err);
        $finish;
    end

endmodule
